// File: rtl/winner_policy_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : winner_policy_param_pkg                                    |
// | Brief   : Shared constants and FSM encoding for the winner-policy    |
// |           engine and its stochastic helpers.                         |
// | Rev     : 1.0  initial parametrised release                          |
// +----------------------------------------------------------------------+
package winner_policy_param_pkg;

  localparam int          WP_WORD_WIDTH    = 16;
  localparam int          WP_NUM_NEIGHBORS = 64;
  localparam int          WP_IDX_W         = 6;
  localparam logic [15:0] WP_QV_BASE       = 16'h01C8;
  localparam logic [15:0] WP_NID_BASE      = 16'h0048;
  localparam int          WP_ADDR_STRIDE   = 2;
  localparam logic [15:0] WP_LFSR_SEED     = 16'hACE1;
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] WP_LFSR_TAPS     = 16'hB400;
  localparam int          WP_EPS_MIN       = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DECIDE = 3'd2,
    ST_REDUCE = 3'd3,
    ST_FETCH  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6
  } wp_state_e;

endpackage
`default_nettype wire

// File: rtl/wp_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wp_lfsr                                                    |
// | Brief   : Seeded 16-bit Galois LFSR with advance enable.             |
// | Rev     : 1.0  initial parametrised release                          |
// +----------------------------------------------------------------------+
module wp_lfsr
  import winner_policy_param_pkg::*;
#(
  parameter logic [15:0] SEED = WP_LFSR_SEED,
  parameter logic [15:0] TAPS = WP_LFSR_TAPS
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        i_en,
  output logic [15:0] o_value
);

  logic [15:0] r_value;

  // Shift right; when the bit falling out is 1, fold the tap mask back in
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_value <= SEED;
    end else if (i_en) begin
      r_value <= {1'b0, r_value[15:1]} ^ (r_value[0] ? TAPS : 16'h0000);
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/winner_policy_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : winner_policy_param                                        |
// | Brief   : Scans neighbour Q-values in shared memory, makes an        |
// |           epsilon-greedy choice and fetches the next-hop ID.         |
// | Rev     : 1.0  initial parametrised release                          |
// +----------------------------------------------------------------------+
module winner_policy_param
  import winner_policy_param_pkg::*;
#(
  parameter int                    WORD_WIDTH    = WP_WORD_WIDTH,
  parameter int                    NUM_NEIGHBORS = WP_NUM_NEIGHBORS,
  parameter int                    IDX_W         = WP_IDX_W,
  parameter logic [WORD_WIDTH-1:0] QV_BASE       = WORD_WIDTH'(WP_QV_BASE),
  parameter logic [WORD_WIDTH-1:0] NID_BASE      = WORD_WIDTH'(WP_NID_BASE),
  parameter int                    ADDR_STRIDE   = WP_ADDR_STRIDE,
  parameter logic [15:0]           LFSR_SEED     = WP_LFSR_SEED,
  parameter int                    EPS_MIN       = WP_EPS_MIN
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  am_sink,
  input  logic [IDX_W:0]        num_nbr,
  input  logic [WORD_WIDTH-1:0] my_best,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] eps_init,
  input  logic                  eps_load,
  input  logic [WORD_WIDTH-1:0] eps_step,
  output logic [WORD_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [WORD_WIDTH-1:0] nexthop,
  output logic [WORD_WIDTH-1:0] best_qvalue,
  output logic                  explored,
  output logic                  no_route,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] eps_cur,
  output logic [WORD_WIDTH-1:0] rng_out
);

  localparam logic [IDX_W:0]        c_max_nbr = (IDX_W+1)'(NUM_NEIGHBORS);
  localparam logic [IDX_W:0]        c_one     = (IDX_W+1)'(1);
  localparam logic [WORD_WIDTH-1:0] c_stride  = WORD_WIDTH'(ADDR_STRIDE);
  localparam logic [WORD_WIDTH-1:0] c_eps_min = WORD_WIDTH'(EPS_MIN);

  wp_state_e             r_state, w_state_nxt;
  logic [IDX_W:0]        r_idx, r_num, r_cand;
  logic [IDX_W-1:0]      r_best_idx;
  logic [WORD_WIDTH-1:0] r_my_best, r_my_id, r_best_q, r_address, r_nexthop, r_eps;
  logic                  r_explored, r_no_route, r_done;

  logic [15:0]           w_lfsr;
  logic [IDX_W:0]        w_num_in, w_idx_inc, w_prev_idx;
  logic [WORD_WIDTH-1:0] w_qv_addr_nxt, w_nid_addr_cand, w_nid_addr_best;
  logic [WORD_WIDTH-1:0] w_eps_diff, w_eps_dec;
  logic                  w_direct, w_best_le, w_explore, w_cand_ge, w_busy;

  wp_lfsr #(
    .SEED (LFSR_SEED),
    .TAPS (WP_LFSR_TAPS)
  ) u_lfsr (
    .clock   (clock),
    .nreset  (nreset),
    .i_en    (1'b1),
    .o_value (w_lfsr)
  );

  // Requests above the table capacity are clamped to the table size
  assign w_num_in   = (num_nbr > c_max_nbr) ? c_max_nbr : num_nbr;
  assign w_direct   = am_sink || (w_num_in == '0);
  assign w_idx_inc  = r_idx + c_one;
  assign w_prev_idx = r_idx - c_one;

  // Address arithmetic wraps naturally at WORD_WIDTH bits
  assign w_qv_addr_nxt   = QV_BASE + c_stride * WORD_WIDTH'(w_idx_inc);
  assign w_nid_addr_cand = NID_BASE + c_stride * WORD_WIDTH'(r_cand);
  assign w_nid_addr_best = NID_BASE + c_stride * WORD_WIDTH'(r_best_idx);

  assign w_best_le = (r_best_q <= r_my_best);
  assign w_explore = (WORD_WIDTH'(w_lfsr[7:0]) < r_eps);
  assign w_cand_ge = (r_cand >= r_num);

  // Decay saturates at the floor instead of wrapping below zero
  assign w_eps_diff = r_eps - eps_step;
  assign w_eps_dec  = ((r_eps >= eps_step) && (w_eps_diff > c_eps_min)) ? w_eps_diff : c_eps_min;

  // State register
  always_ff @(posedge clock) begin
    if (!nreset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and busy flag
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = w_direct ? ST_DONE : ST_SCAN;
      end
      ST_SCAN:   if (r_idx == r_num) w_state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (w_best_le)      w_state_nxt = ST_DONE;
        else if (w_explore) w_state_nxt = ST_REDUCE;
        else                w_state_nxt = ST_FETCH;
      end
      ST_REDUCE: if (!w_cand_ge) w_state_nxt = ST_FETCH;
      ST_FETCH:  w_state_nxt = ST_WAIT;
      ST_WAIT:   w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch request, pipelined max scan, decision, ID fetch
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_idx      <= '0;
      r_num      <= '0;
      r_cand     <= '0;
      r_best_idx <= '0;
      r_my_best  <= '0;
      r_my_id    <= '0;
      r_best_q   <= '0;
      r_address  <= '0;
      r_nexthop  <= '0;
      r_eps      <= eps_init;
      r_explored <= 1'b0;
      r_no_route <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (eps_load) r_eps <= eps_init;
          if (start) begin
            r_num      <= w_num_in;
            r_my_best  <= my_best;
            r_my_id    <= my_node_id;
            r_explored <= 1'b0;
            r_no_route <= 1'b0;
            r_best_q   <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
            if (w_direct) begin
              r_nexthop  <= my_node_id;
              r_no_route <= 1'b1;
            end else begin
              r_address <= QV_BASE;
            end
          end
        end
        ST_SCAN: begin
          // Memory returns entry idx-1 while idx is being addressed
          if ((r_idx != '0) && (mem_data_out > r_best_q)) begin
            r_best_q   <= mem_data_out;
            r_best_idx <= w_prev_idx[IDX_W-1:0];
          end
          if (w_idx_inc < r_num) r_address <= w_qv_addr_nxt;
          r_idx <= w_idx_inc;
        end
        ST_DECIDE: begin
          r_eps <= w_eps_dec;
          if (w_best_le) begin
            r_nexthop  <= r_my_id;
            r_no_route <= 1'b1;
          end else if (w_explore) begin
            r_explored <= 1'b1;
            r_cand     <= {1'b0, w_lfsr[IDX_W-1:0]};
          end else begin
            r_cand    <= {1'b0, r_best_idx};
            r_address <= w_nid_addr_best;
          end
        end
        ST_REDUCE: begin
          // Modulo by repeated subtraction; address is set up on the last pass
          if (w_cand_ge) r_cand    <= r_cand - r_num;
          else           r_address <= w_nid_addr_cand;
        end
        ST_WAIT:   r_nexthop <= mem_data_out;
        default:   ;
      endcase
    end
  end

  assign address     = r_address;
  assign nexthop     = r_nexthop;
  assign best_qvalue = r_best_q;
  assign explored    = r_explored;
  assign no_route    = r_no_route;
  assign busy        = w_busy;
  assign done        = r_done;
  assign eps_cur     = r_eps;
  assign rng_out     = WORD_WIDTH'(w_lfsr);

endmodule
`default_nettype wire

// File: doc/winner_policy_param.md
Name: winner_policy_param

Overview:
Parametrised successor to the V2 winner-policy engine for the Q-routing datapath.
- On a start request it scans the Q-values of up to NUM_NEIGHBORS neighbours held in shared memory and finds the best one.
- It makes an epsilon-greedy explore/exploit decision using an internal LFSR, then fetches the chosen neighbour's ID as the next hop.
- It decays its own epsilon after every decision.
- It sits between the reward/Q-update logic and the packet-forwarding FSM, and shares the single-port memory through an address/data interface.

Parameters:
WORD_WIDTH, 16, data/address width
NUM_NEIGHBORS, 64, maximum neighbour table entries
IDX_W, 6, index width (clog2 NUM_NEIGHBORS)
QV_BASE, 16'h01C8, qValue table base address
NID_BASE, 16'h0048, neighborID table base address
ADDR_STRIDE, 2, address increment per word entry
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)
EPS_MIN, 0, epsilon floor

Ports:
clock  in  1  system clock, all logic on rising edge
nreset  in  1  synchronous active-low reset
start  in  1  decision request, sampled in IDLE only
am_sink  in  1  node is a sink
num_nbr  in  IDX_W+1  valid neighbour count, latched on start
my_best  in  WORD_WIDTH  own current best Q-value
my_node_id  in  WORD_WIDTH  own node ID
eps_init  in  WORD_WIDTH  epsilon load value
eps_load  in  1  load eps_init into epsilon register
eps_step  in  WORD_WIDTH  decay per decision
address  out  WORD_WIDTH  memory read address
mem_data_out  in  WORD_WIDTH  memory read data, valid 1 cycle after address
nexthop  out  WORD_WIDTH  selected next hop, held until next decision
best_qvalue  out  WORD_WIDTH  maximum neighbour Q-value found
explored  out  1  last decision was exploratory
no_route  out  1  sink, empty table, or my_best >= best neighbour
busy  out  1  high outside IDLE/DONE
done  out  1  one-cycle completion pulse
eps_cur  out  WORD_WIDTH  current epsilon
rng_out  out  WORD_WIDTH  current LFSR value

Behaviour:
Reset:
- While nreset=0 at a clock edge, all outputs clear to 0 except eps_cur<=eps_init and rng_out<=LFSR_SEED.
- FSM goes to IDLE; any in-flight decision is aborted with no done pulse.

LFSR:
- 16-bit Galois LFSR, taps 16,14,13,11.
- Advances every cycle outside reset.

eps_load:
- When eps_load=1 in IDLE, eps_cur<=eps_init.
- Ignored while busy.

IDLE:
- start=1 latches num_nbr/my_best/my_node_id; clears explored/no_route.
- If am_sink=1 or num_nbr=0 -> DONE, with nexthop=my_node_id, no_route=1.
- Otherwise -> SCAN, with idx=0.

SCAN (pipelined, num_nbr+1 cycles):
- Cycle k drives address=QV_BASE+ADDR_STRIDE*k for k<num_nbr.
- Data for entry k-1 is compared the same cycle.
- Strict greater-than update, so on ties the lowest index wins.
- Comparison is unsigned.
- Exit -> DECIDE.

DECIDE (1 cycle):
- If best_qvalue <= my_best: nexthop=my_node_id, no_route=1 -> DONE.
- Else if rng_out[7:0] < eps_cur: explore, cand=rng_out[IDX_W-1:0], explored=1 -> REDUCE.
- Otherwise exploit, cand=best_idx -> FETCH.
- eps_cur <= max(eps_cur-eps_step, EPS_MIN) on every DECIDE, computed without underflow.

REDUCE:
- While cand>=num_nbr, cand<=cand-num_nbr, one subtraction per cycle.
- Then -> FETCH.

FETCH:
- address=NID_BASE+ADDR_STRIDE*cand -> WAIT.

WAIT:
- nexthop<=mem_data_out -> DONE.

DONE:
- done=1 for exactly one cycle -> IDLE.
- start is ignored during DONE.

Latency:
- Exploit path: done is asserted num_nbr+5 cycles after the start edge.
- Sink or empty table: 1 cycle.
- Explore path adds the REDUCE iterations.

Address:
- Holds its last value when not reading.
- Address arithmetic is modulo 2^WORD_WIDTH.

Decomposition:
- Shared package: WORD_WIDTH, table base addresses, ADDR_STRIDE, FSM state encoding, LFSR tap constant.
- One sub-module: wp_lfsr (seeded Galois LFSR with enable), reused by other stochastic blocks.

Test Plan:
1. Exploit path: num_nbr=4, qValues {3,9,9,2}, neighborIDs {10,11,12,13}, my_best=1, eps_init=0 -> nexthop=11, best_qvalue=9, explored=0, done exactly 9 cycles after start, eps_cur stays 0.
2. No route: same table, my_best=20 -> nexthop=my_node_id=5, no_route=1; am_sink=1 -> done 1 cycle after start, nexthop=5, no memory reads.
3. Forced explore: eps_init=16'h0100, num_nbr=3 -> explored=1, nexthop equals the neighborID at index (rng_out[5:0] mod 3) computed by the bench model; eps_step=1 gives eps_cur=16'h00FF afterwards.
4. Epsilon decay saturation: eps_init=2, eps_step=3 -> eps_cur=0 after the first decision and remains 0 after a second; EPS_MIN=1 build -> floors at 1.
5. Reset mid-SCAN: assert nreset=0 for 1 cycle during SCAN -> no done pulse; outputs zero; eps_cur=eps_init; rng_out=16'hACE1; a subsequent start completes normally.
6. Full table: num_nbr=64 with the maximum at index 63 -> nexthop=NID[63], last Q address 16'h0246, back-to-back starts each produce exactly one done pulse.
